// File: rtl/traffic_pkg.sv
// Shared state encodings, light constants and the fixed phase order of the
// two-approach intersection controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        NSG = 3'd0,
        NSY = 3'd1,
        ARN = 3'd2,
        EWG = 3'd3,
        EWY = 3'd4,
        ARE = 3'd5
    } state_t;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    // Illegal encodings fall back to NSG so the controller always recovers.
    function automatic state_t next_state(state_t s);
        case (s)
            NSG:     return NSY;
            NSY:     return ARN;
            ARN:     return EWG;
            EWG:     return EWY;
            EWY:     return ARE;
            default: return NSG;
        endcase
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks;
// the first tick lands TICK_DIV clocks after reset release.
module tick_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == W'(TICK_DIV - 1));

    // NOTE: combinational blocks use blocking '=' and assign every output on
    // every path, so no latch can be inferred.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + W'(1);
    end

    // NOTE: flops use non-blocking '<=' so every register samples the values
    // from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Six-phase NS/EW traffic light controller with tick-based phase timers,
// optional actuated NS green hold and a latched pedestrian walk request.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_T  = 10,
    parameter int YELLOW_T = 2,
    parameter int ALLRED_T = 1,
    parameter int TICK_DIV = 1,
    parameter int CNT_W    = 4,
    parameter int ACTUATED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ew_sensor,
    input  logic             ped_req,
    output logic [2:0]       NS_light,
    output logic [2:0]       EW_light,
    output logic             walk,
    output logic [CNT_W-1:0] clk_count,
    output logic [2:0]       state
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             ped_q, ped_d;
    logic             walk_q, walk_d;
    logic             tick;
    logic             advance;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_prescaler (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    function automatic logic [CNT_W-1:0] dur_of(state_t s);
        case (s)
            NSY, EWY: return CNT_W'(YELLOW_T - 1);
            ARN, ARE: return CNT_W'(ALLRED_T - 1);
            default:  return CNT_W'(GREEN_T - 1);
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= NSG;
            cnt_q   <= CNT_W'(GREEN_T - 1);
            req_q   <= 1'b0;
            ped_q   <= 1'b0;
            walk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ped_q   <= ped_d;
            walk_q  <= walk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q | ew_sensor | ped_req;
        ped_d   = ped_q | ped_req;
        walk_d  = walk_q;
        advance = 1'b0;

        case (state_q)
            NSG, NSY, ARN, EWG, EWY, ARE: begin
                if (tick) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (state_q != NSG || ACTUATED == 0 || req_q) begin
                        advance = 1'b1;
                    end
                end
            end
            default: begin
                state_d = NSG;
                cnt_d   = dur_of(NSG);
            end
        endcase

        // Entering EWG consumes both requests; a same-cycle request is dropped
        // here and re-latched on the following clock if it is still present.
        if (advance) begin
            state_d = next_state(state_q);
            cnt_d   = dur_of(state_d);
            if (state_d == EWG) begin
                req_d  = 1'b0;
                walk_d = ped_q;
                ped_d  = 1'b0;
            end else if (state_d == EWY) begin
                walk_d = 1'b0;
            end
        end
    end

    always_comb begin
        NS_light = RED;
        EW_light = RED;
        case (state_q)
            NSG:     NS_light = GREEN;
            NSY:     NS_light = YELLOW;
            EWG:     EW_light = GREEN;
            EWY:     EW_light = YELLOW;
            default: ;
        endcase
    end

    assign walk      = walk_q;
    assign clk_count = cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: three instances (fixed-time,
// TICK_DIV=4, actuated) share clock and reset; each has its own request inputs.
module tb_traffic_light_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] cnt;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
    } obs_t;

    logic clk;
    logic rst;

    logic       ew_f, ped_f, walk_f;
    logic [2:0] ns_f, ewl_f, st_f;
    logic [3:0] cnt_f;

    logic       ew_d, ped_d, walk_d;
    logic [2:0] ns_d, ewl_d, st_d;
    logic [3:0] cnt_d;

    logic       ew_a, ped_a, walk_a;
    logic [2:0] ns_a, ewl_a, st_a;
    logic [3:0] cnt_a;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    traffic_light_ctrl dut_fix (
        .clk(clk), .rst(rst), .ew_sensor(ew_f), .ped_req(ped_f),
        .NS_light(ns_f), .EW_light(ewl_f), .walk(walk_f),
        .clk_count(cnt_f), .state(st_f)
    );

    traffic_light_ctrl #(.TICK_DIV(4)) dut_div (
        .clk(clk), .rst(rst), .ew_sensor(ew_d), .ped_req(ped_d),
        .NS_light(ns_d), .EW_light(ewl_d), .walk(walk_d),
        .clk_count(cnt_d), .state(st_d)
    );

    traffic_light_ctrl #(.ACTUATED(1)) dut_act (
        .clk(clk), .rst(rst), .ew_sensor(ew_a), .ped_req(ped_a),
        .NS_light(ns_a), .EW_light(ewl_a), .walk(walk_a),
        .clk_count(cnt_a), .state(st_a)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic obs_t sample(int sel);
        obs_t o;
        case (sel)
            0:       begin o.st = st_f; o.cnt = cnt_f; o.ns = ns_f; o.ew = ewl_f; o.walk = walk_f; end
            1:       begin o.st = st_d; o.cnt = cnt_d; o.ns = ns_d; o.ew = ewl_d; o.walk = walk_d; end
            default: begin o.st = st_a; o.cnt = cnt_a; o.ns = ns_a; o.ew = ewl_a; o.walk = walk_a; end
        endcase
        return o;
    endfunction

    function automatic obs_t make_obs(int st, int cnt, logic walk);
        obs_t o;
        o.st   = 3'(st);
        o.cnt  = 4'(cnt);
        o.walk = walk;
        o.ns   = 3'b100;
        o.ew   = 3'b100;
        case (st)
            0: o.ns = 3'b001;
            1: o.ns = 3'b010;
            3: o.ew = 3'b001;
            4: o.ew = 3'b010;
            default: ;
        endcase
        return o;
    endfunction

    // Expected per-clock trace of an unextended cycle, indexed from reset release:
    // each phase shows counts d-1..0, each held for tick_div clocks.
    task automatic push_cycle(input int tick_div, input int n, input int walk_lo, input int walk_hi);
        int durs[6] = '{10, 2, 1, 10, 2, 1};
        int idx = 0;
        while (idx < n) begin
            for (int s = 0; s < 6; s++) begin
                for (int c = durs[s] - 1; c >= 0; c--) begin
                    for (int k = 0; k < tick_div; k++) begin
                        if (idx < n) begin
                            exp_q.push_back(make_obs(s, c, (idx >= walk_lo && idx <= walk_hi)));
                        end
                        idx++;
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        ew_f  = 1'b0; ped_f = 1'b0;
        ew_d  = 1'b0; ped_d = 1'b0;
        ew_a  = 1'b0; ped_a = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        do_reset();
        rst = 1'b0;
        #3;
        exp = make_obs(0, 9, 1'b0);
        for (int s = 0; s < 3; s++) begin
            got = sample(s);
            n_checks++;
            if (got !== exp)
                $display("FAIL reset dut%0d: got %h expected %h", s, got, exp);
            else
                n_pass++;
        end
    endtask

    task automatic test_fixed_cycle();
        obs_t got, exp;
        do_reset();
        push_cycle(1, 27, -1, -1);
        for (int i = 0; i < 27; i++) begin
            #1;
            got = sample(0);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp)
                $display("FAIL fixed_cycle idx=%0d: got st=%0d cnt=%0d ns=%b ew=%b walk=%b, expected st=%0d cnt=%0d ns=%b ew=%b walk=%b",
                         i, got.st, got.cnt, got.ns, got.ew, got.walk, exp.st, exp.cnt, exp.ns, exp.ew, exp.walk);
            else
                n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_tick_div();
        obs_t got, exp;
        do_reset();
        push_cycle(4, 46, -1, -1);
        for (int i = 0; i < 46; i++) begin
            #1;
            got = sample(1);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp)
                $display("FAIL tick_div idx=%0d: got st=%0d cnt=%0d, expected st=%0d cnt=%0d (lights %b/%b vs %b/%b)",
                         i, got.st, got.cnt, exp.st, exp.cnt, got.ns, got.ew, exp.ns, exp.ew);
            else
                n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_actuated_hold();
        obs_t got, exp;
        do_reset();
        for (int i = 0; i < 102; i++)
            exp_q.push_back(make_obs(0, (i < 10) ? 9 - i : 0, 1'b0));
        exp_q.push_back(make_obs(1, 1, 1'b0));
        for (int i = 0; i < 103; i++) begin
            if (i == 100) ew_a = 1'b1;
            if (i == 101) ew_a = 1'b0;
            #1;
            got = sample(2);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp)
                $display("FAIL actuated_hold idx=%0d: got st=%0d cnt=%0d, expected st=%0d cnt=%0d",
                         i, got.st, got.cnt, exp.st, exp.cnt);
            else
                n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_ped_walk();
        obs_t got, exp;
        do_reset();
        push_cycle(1, 53, 13, 22);
        for (int i = 0; i < 53; i++) begin
            if (i == 3) ped_f = 1'b1;
            if (i == 4) ped_f = 1'b0;
            #1;
            got = sample(0);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp)
                $display("FAIL ped_walk idx=%0d: got st=%0d walk=%b, expected st=%0d walk=%b",
                         i, got.st, got.walk, exp.st, exp.walk);
            else
                n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        obs_t got, exp;
        do_reset();
        push_cycle(1, 24, -1, -1);
        for (int i = 0; i < 24; i++) begin
            #1;
            got = sample(0);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp)
                $display("FAIL async_reset_lead idx=%0d: got st=%0d cnt=%0d, expected st=%0d cnt=%0d",
                         i, got.st, got.cnt, exp.st, exp.cnt);
            else
                n_pass++;
            @(negedge clk);
        end
        // Now mid-EWY, well before the next rising edge.
        #2;
        rst = 1'b0;
        #1;
        exp = make_obs(0, 9, 1'b0);
        for (int s = 0; s < 2; s++) begin
            got = sample(s);
            n_checks++;
            if (got !== exp)
                $display("FAIL async_reset dut%0d: got %h expected %h", s, got, exp);
            else
                n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, exp;
        do_reset();
        push_cycle(1, 38, -1, -1);
        for (int i = 0; i < 38; i++) begin
            if (i == 2)  ew_a = 1'b1;
            if (i == 15) ew_a = 1'b0;
            #1;
            got = sample(2);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp)
                $display("FAIL back_to_back idx=%0d: got st=%0d cnt=%0d, expected st=%0d cnt=%0d",
                         i, got.st, got.cnt, exp.st, exp.cnt);
            else
                n_pass++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst  = 1'b0;
        ew_f = 1'b0; ped_f = 1'b0;
        ew_d = 1'b0; ped_d = 1'b0;
        ew_a = 1'b0; ped_a = 1'b0;
        test_reset();
        test_fixed_cycle();
        test_tick_div();
        test_actuated_hold();
        test_ped_walk();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 SHALL have parameter GREEN_T, default 10, minimum green duration in ticks (>=1).
REQ-002 SHALL have parameter YELLOW_T, default 2, yellow duration in ticks (>=1).
REQ-003 SHALL have parameter ALLRED_T, default 1, all-red clearance duration in ticks (>=1).
REQ-004 SHALL have parameter TICK_DIV, default 1, clock cycles per tick (>=1).
REQ-005 SHALL have parameter CNT_W, default 4, timer width; must hold max(GREEN_T,YELLOW_T,ALLRED_T)-1.
REQ-006 SHALL have parameter ACTUATED, default 0; 0 = fixed-time, 1 = NS green held until an EW/ped request.
REQ-007 SHALL have port clk  input  1  single system clock; all state changes on posedge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port ew_sensor  input  1  vehicle waiting on EW approach, level, sampled each clk.
REQ-010 SHALL have port ped_req  input  1  pedestrian button, level, sampled each clk.
REQ-011 SHALL have port NS_light  output  3  one-hot light: red 100, yellow 010, green 001.
REQ-012 SHALL have port EW_light  output  3  same encoding as NS_light.
REQ-013 SHALL have port walk  output  1  pedestrian walk indication.
REQ-014 SHALL have port clk_count  output  CNT_W  ticks remaining in current state.
REQ-015 SHALL have port state  output  3  current state encoding.

Function
REQ-016 SHALL implement states NSG=0, NSY=1, ARN=2, EWG=3, EWY=4, ARE=5, cycled NSG>NSY>ARN>EWG>EWY>ARE>NSG.
REQ-017 SHALL drive lights combinationally from state: NSG NS=001/EW=100; NSY 010/100; ARN, ARE 100/100; EWG 100/001; EWY 100/010.
REQ-018 SHALL generate a one-cycle tick every TICK_DIV clocks from a free-running prescaler; TICK_DIV=1 means tick every cycle.
REQ-019 SHALL load clk_count with duration-1 of the entered state on every transition (GREEN_T for NSG/EWG, YELLOW_T for NSY/EWY, ALLRED_T for ARN/ARE).
REQ-020 SHALL decrement clk_count by 1 on each tick while nonzero; never wrap below 0.
REQ-021 SHALL transition only on a tick with clk_count==0, so each timed state lasts exactly duration*TICK_DIV clocks.
REQ-022 SHALL, when ACTUATED=1, hold NSG with clk_count==0 until the request latch is set, then transition on the next tick.
REQ-023 SHALL set the request latch when ew_sensor or ped_req is high in any cycle; cleared on the clock that enters EWG (clear wins over a same-cycle set).
REQ-024 SHALL set a ped latch on ped_req; on entry to EWG copy it into walk and clear it; deassert walk on entry to EWY.
REQ-025 SHALL ignore requests for timing when ACTUATED=0, but still serve walk per REQ-024.
REQ-026 SHALL, from illegal state 6 or 7, enter NSG on the next clock with clk_count=GREEN_T-1.

Reset
REQ-027 SHALL, while rst low, force state=NSG, NS_light=001, EW_light=100, clk_count=GREEN_T-1, prescaler=0, both latches=0, walk=0.
REQ-028 SHALL apply reset immediately regardless of clk; mid-cycle reset in any state returns to REQ-027 values; first tick occurs TICK_DIV clocks after release.

Structure
REQ-029 SHALL place state encodings and light constants (RED, YELLOW, GREEN) in shared package traffic_pkg.
REQ-030 SHALL instantiate sub-module tick_prescaler (parameter TICK_DIV, ports clk, rst, tick).

Verification
REQ-031 SHALL check defaults, TICK_DIV=1: after reset release NSG 10 clk, NSY 2, ARN 1, EWG 10, EWY 2, ARE 1, back to NSG at clock 26.
REQ-032 SHALL check TICK_DIV=4: NSG lasts 40 clocks, clk_count steps 9..0 every 4 clocks.
REQ-033 SHALL check ACTUATED=1, no requests for 100 clocks -> state stays NSG, clk_count=0; pulse ew_sensor 1 cycle -> NSY on next tick.
REQ-034 SHALL check ped_req pulse during NSG -> walk=1 for exactly the 10 EWG clocks, 0 elsewhere; latch clear afterwards.
REQ-035 SHALL check rst asserted asynchronously mid-EWY -> outputs take REQ-027 values before next clk edge.
REQ-036 SHALL check ew_sensor held high across EWG entry (ACTUATED=1) -> latch re-sets next cycle, next NSG lasts exactly 10 clocks.
